dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous data RAM between two requesters:
//  port C (CPU load/store path) and port D (debug/program-loader).
//  Round-robin arbitration with a req/gnt handshake; one access in flight at a time.
//  Read data returns through the granted port with an rvalid pulse.
//  Sits between the CPU datapath/debug logic and data_ram.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports
//  RD_LAT  1   data_ram read latency in cycles (legal 1..4)
// PORTS
//  clk         in   1       system clock, all logic rising-edge
//  rst         in   1       reset, asynchronous, active-high
//  c_req       in   1       port C access request, held until c_gnt
//  c_we        in   1       port C 1=write 0=read
//  c_addr      in   ADDR_W  port C address
//  c_wdata     in   DATA_W  port C write data
//  c_gnt       out  1       1-cycle pulse: port C access issued to RAM this cycle
//  c_rvalid    out  1       1-cycle pulse: c_rdata valid
//  c_rdata     out  DATA_W  port C read data
//  d_req/d_we/d_addr/d_wdata/d_gnt/d_rvalid/d_rdata   same as port C, port D
//  mem_addr    out  ADDR_W  to data_ram address
//  mem_wdata   out  DATA_W  to data_ram data
//  mem_wren    out  1       to data_ram write enable
//  mem_rdata   in   DATA_W  from data_ram q
//  busy        out  1       1 when FSM not in IDLE
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE, last_win=D (so C wins first tie),
//   all outputs 0, both rdata registers 0, wait counter 0.
//  FSM: IDLE -> ISSUE -> (write) IDLE
//                     -> (read)  WAIT x RD_LAT -> RESP -> IDLE
//  IDLE: if c_req|d_req, register winner sel and go ISSUE; else stay.
//   Only one requesting: it wins. Both: winner = !last_win. last_win<=sel.
//  ISSUE (1 cycle): mem_addr/mem_wdata/mem_wren from sel port's inputs
//   (mem_wren = sel port we); gnt of sel port =1; other gnt =0.
//   Requester must hold req/we/addr/wdata stable from req rise through gnt;
//   ISSUE uses current inputs regardless, and the bench flags instability.
//   Write: next IDLE. Read: next WAIT with counter loaded RD_LAT-1.
//  WAIT: mem_wren=0, mem_addr held; counter decrements; on last WAIT cycle
//   (counter==0) capture mem_rdata into sel port rdata register; go RESP.
//  RESP (1 cycle): sel port rvalid=1; rdata register holds until next capture.
//  Timing: gnt at cycle t; read rvalid at t+RD_LAT+1.
//   Write occupies 2 cycles (IDLE+ISSUE); read occupies RD_LAT+3 cycles.
//   Same port re-requesting after gnt is seen next IDLE; no back-to-back ISSUE.
//  mem_addr/mem_wdata=0 and mem_wren=0 in IDLE and RESP.
//   WAIT keeps mem_addr, mem_wdata=0, mem_wren=0.
//  Non-granted port: gnt=0, rvalid=0, rdata unchanged.
//  busy=1 in ISSUE/WAIT/RESP.
//  Reset mid-transaction: access abandoned, no rvalid, no further mem_wren;
//   write already issued in ISSUE stays committed in RAM.
//  req deasserted while in IDLE with no other req: no grant, stay IDLE.
// TESTING
//  1 c_req write addr 0x10 data 0xDEADBEEF at cycle 0 -> c_gnt, mem_wren=1,
//    mem_addr=0x10 at cycle 1 only; busy low cycle 2.
//  2 then d_req read addr 0x10 -> d_gnt at t, d_rvalid at t+2,
//    d_rdata=0xDEADBEEF; c_rvalid stays 0.
//  3 c_req and d_req both held high from reset release, 4 writes each ->
//    grant order C,D,C,D,... and neither port waits more than one transaction.
//  4 only d_req held, continuous reads -> d_gnt every 4 cycles (RD_LAT=1),
//    c_gnt never pulses.
//  5 rst pulsed during WAIT of a C read -> all outputs 0 immediately, no c_rvalid;
//    next tie grants C first.
//  6 RD_LAT=3 build, C read of 0x20 holding 0x12345678 -> c_rvalid exactly
//    4 cycles after c_gnt, c_rdata=0x12345678.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between
// the CPU load/store port (C) and the debug/program-loader port (D).
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_t            state, state_nxt;
    logic              sel;       // 0 = port C, 1 = port D
    logic              last_win;
    logic              win;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel_we    = sel ? d_we    : c_we;
    assign sel_addr  = sel ? d_addr  : c_addr;
    assign sel_wdata = sel ? d_wdata : c_wdata;

    // A lone requester always wins; a tie goes to the port that did not win last.
    assign win = (c_req && d_req) ? ~last_win : d_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (c_req || d_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = sel_we ? S_IDLE : S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= 1'b0;
            last_win  <= 1'b1;
            cnt       <= '0;
            addr_q    <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (c_req || d_req) begin
                        sel      <= win;
                        last_win <= win;
                    end
                end
                S_ISSUE: begin
                    cnt    <= CNT_LOAD;
                    addr_q <= sel_addr;
                end
                S_WAIT: begin
                    if (cnt != '0) cnt <= cnt - 2'd1;
                    else if (sel)  d_rdata_q <= mem_rdata;
                    else           c_rdata_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        unique case (state)
            S_ISSUE: begin
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
                mem_wren  = sel_we;
                c_gnt     = ~sel;
                d_gnt     = sel;
            end
            S_WAIT: mem_addr = addr_q;
            S_RESP: begin
                c_rvalid = ~sel;
                d_rvalid = sel;
            end
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
